reg_file_arbiter: RTL and testbench
===================================

REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

Interface
REQ-001 Parameter DATA_W, default 9, is the register file data width.
REQ-002 Parameter ADDR_W, default 3, is the register file address width (8 entries).
REQ-003 Port CLK  input  1  is the single clock; all state changes occur on its rising edge.
REQ-004 Port RST  input  1  is the reset, asynchronous and active-high.
REQ-005 Port REQ  input  2  holds the per-requester access request (index 0 = requester A, 1 = requester B).
REQ-006 Port WR  input  2  selects the per-requester operation (1 = write, 0 = read).
REQ-007 Port ADDR  input  2 x ADDR_W  holds the per-requester target register.
REQ-008 Port WDATA  input  2 x DATA_W  holds the per-requester write data.
REQ-009 Port GNT  output  2  is the one-hot, single-cycle grant pulse.
REQ-010 Port RVALID  output  2  is the one-hot, single-cycle read-data-valid pulse.
REQ-011 Port RDATA  output  DATA_W  is the read data shared by both requesters and qualified by RVALID.
REQ-012 Ports RF_WEN, RF_OEN (output 1 each), RF_ADDR (output ADDR_W) and RF_DIN (output DATA_W) drive the register file bus.
REQ-013 Port RF_DOUT  input  DATA_W  carries the register file output, which the register file latches on the rising edge when RF_OEN=1.

Function
REQ-014 The FSM SHALL have three states: IDLE, ISSUE and CAPTURE.
REQ-015 IDLE: with any REQ bit set, the FSM SHALL pick a winner, latch its WR/ADDR/WDATA into internal registers, and move to ISSUE; with no REQ bit set, it SHALL stay in IDLE.
REQ-016 Round-robin: with both REQ bits set, the requester not served last SHALL win; with one REQ bit set, that requester SHALL win regardless of the pointer.
REQ-017 The last-served pointer SHALL update only on entry to ISSUE.
REQ-018 ISSUE (exactly 1 cycle): GNT[winner]=1; RF_ADDR and RF_DIN SHALL equal the latched values; write drives RF_WEN=1, RF_OEN=0; read drives RF_WEN=0, RF_OEN=1.
REQ-019 ISSUE exit: a write SHALL return to IDLE; a read SHALL go to CAPTURE.
REQ-020 CAPTURE (exactly 1 cycle): RVALID[winner]=1 and RDATA=RF_DOUT; then return to IDLE.
REQ-021 Latency, with REQ seen in IDLE at cycle N: GNT at N+1, write committed at the end of N+1, RVALID/RDATA at N+2.
REQ-022 Throughput: a write SHALL take 2 cycles per access and a read 3; a new arbitration SHALL occur in the first IDLE cycle after completion.
REQ-023 Requesters SHALL hold REQ and the command stable until GNT; dropping REQ before the arbiter latches it cancels the request without side effects.
REQ-024 Once latched, a command SHALL complete even if REQ drops, and input changes during ISSUE/CAPTURE SHALL be ignored.
REQ-025 Outside ISSUE, RF_WEN=RF_OEN=0; outside CAPTURE, RVALID=0 and RDATA=0.
REQ-026 The write data path SHALL not truncate or extend data: RF_DIN is DATA_W bits wide, and ADDR covers all 2^ADDR_W entries with no reserved addresses.

Reset
REQ-027 Asserting RST SHALL immediately force IDLE, GNT=0, RVALID=0, RDATA=0, RF_WEN=0, RF_OEN=0, RF_ADDR=0, RF_DIN=0, and the pointer to "last served = B" (A wins the first tie).
REQ-028 Reset during ISSUE or CAPTURE SHALL abort the access: no GNT/RVALID after release, and the in-flight command is lost.
REQ-029 After RST deasserts, arbitration SHALL start on the first rising edge.

Structure
REQ-030 Package reg_file_pkg SHALL hold DATA_W/ADDR_W defaults and the state enum (IDLE, ISSUE, CAPTURE).
REQ-031 The winner-select and pointer logic SHALL live in sub-module rr_arbiter2 (inputs REQ, pointer, and update enable; output one-hot winner).

Verification
REQ-032 Scenario 1: A writes 9'h055 to addr 3, then A reads addr 3 -> GNT[0] on each access, RVALID[0] with RDATA=9'h055 two cycles after the read REQ.
REQ-033 Scenario 2: both request from reset (A write addr 1 = 9'h0AA, B read addr 1) -> A is granted first, B second, and B gets RDATA=9'h0AA.
REQ-034 Scenario 3: both hold REQ for 6 accesses -> grants alternate A,B,A,B,A,B and no requester waits more than one access.
REQ-035 Scenario 4: write all 8 addresses with value addr*9'h021, then read back 0..7 -> each RDATA matches and the RF_WEN/RF_OEN pulses are exactly 1 cycle.
REQ-036 Scenario 5: RST asserted mid-CAPTURE of a B read -> RVALID stays 0, strobes are 0 within the same cycle, and the next tie grants A.
REQ-037 Scenario 6: A raises then drops REQ within the same IDLE cycle before the edge -> no GNT, and RF strobes stay 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared definitions for the two-requester register file arbiter.
package reg_file_pkg;

    // Default register file geometry (8 entries of 9 bits).
    localparam int DATA_W_DEF = 9;
    localparam int ADDR_W_DEF = 3;

    // Number of requesters; index 0 is requester A, index 1 is requester B.
    localparam int N_REQ = 2;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    // Index of the set bit in a two-bit one-hot vector (0 when A or none).
    function automatic logic onehot_idx(input logic [N_REQ-1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select with last-served pointer next-state.
module rr_arbiter2
    import reg_file_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,       // request vector, bit 0 = A, bit 1 = B
    input  logic             i_last,      // last served: 0 = A, 1 = B
    input  logic             i_update,    // arbitration is taking effect this cycle
    output logic [N_REQ-1:0] o_winner,    // one-hot winner, zero when no request
    output logic             o_last_next  // pointer value for the next cycle
);

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        o_winner = '0;
        unique case (i_req)
            2'b01:   o_winner = 2'b01;
            2'b10:   o_winner = 2'b10;
            2'b11:   o_winner = i_last ? 2'b01 : 2'b10;
            default: o_winner = '0;
        endcase
    end

    // Pointer only moves when a winner is actually committed.
    always_comb begin
        o_last_next = i_last;
        if (i_update && (o_winner != '0)) begin
            o_last_next = onehot_idx(o_winner);
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Arbitrates two requesters onto a single synchronous register file port.
// A write occupies IDLE+ISSUE, a read IDLE+ISSUE+CAPTURE.
module reg_file_arbiter
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [N_REQ-1:0]              REQ,
    input  logic [N_REQ-1:0]              WR,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  ADDR,
    input  logic [N_REQ-1:0][DATA_W-1:0]  WDATA,
    output logic [N_REQ-1:0]              GNT,
    output logic [N_REQ-1:0]              RVALID,
    output logic [DATA_W-1:0]             RDATA,
    output logic                          RF_WEN,
    output logic                          RF_OEN,
    output logic [ADDR_W-1:0]             RF_ADDR,
    output logic [DATA_W-1:0]             RF_DIN,
    input  logic [DATA_W-1:0]             RF_DOUT
);

    state_e              r_state;
    state_e              w_state_next;
    logic                r_last;
    logic [N_REQ-1:0]    r_sel;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_update;
    logic [N_REQ-1:0]    w_winner;
    logic                w_last_next;
    logic                w_win_idx;
    logic                w_take;

    // Arbitration is only evaluated while idle; inputs are ignored otherwise.
    assign w_update  = (r_state == IDLE);
    assign w_take    = w_update && (REQ != '0);
    assign w_win_idx = onehot_idx(w_winner);

    rr_arbiter2 u_rr_arbiter2 (
        .i_req       (REQ),
        .i_last      (r_last),
        .i_update    (w_update),
        .o_winner    (w_winner),
        .o_last_next (w_last_next)
    );

    // Next-state decode for the access sequencer.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    w_state_next = w_take ? ISSUE : IDLE;
            ISSUE:   w_state_next = r_wr ? IDLE : CAPTURE;
            CAPTURE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight access.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Last-served pointer; after reset B counts as served so A wins the first tie.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last <= 1'b1;
        end else begin
            r_last <= w_last_next;
        end
    end

    // Command latch: captures the winner's command so later input changes are ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sel   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_take) begin
            r_sel   <= w_winner;
            r_wr    <= WR[w_win_idx];
            r_addr  <= ADDR[w_win_idx];
            r_wdata <= WDATA[w_win_idx];
        end
    end

    // Outputs decode from state alone so reset clears them without waiting for a clock.
    always_comb begin
        GNT     = '0;
        RVALID  = '0;
        RDATA   = '0;
        RF_WEN  = 1'b0;
        RF_OEN  = 1'b0;
        RF_ADDR = '0;
        RF_DIN  = '0;
        unique case (r_state)
            ISSUE: begin
                GNT     = r_sel;
                RF_WEN  = r_wr;
                RF_OEN  = ~r_wr;
                RF_ADDR = r_addr;
                RF_DIN  = r_wdata;
            end
            CAPTURE: begin
                RVALID = r_sel;
                RDATA  = RF_DOUT;
            end
            default: begin
            end
        endcase
    end

    // Structural invariants of the bus handshake.
    a_gnt_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(GNT));
    a_rvalid_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(RVALID));
    a_strobe_excl: assert property (@(posedge CLK) disable iff (RST) !(RF_WEN && RF_OEN));
    a_issue_single: assert property (@(posedge CLK) disable iff (RST)
                                     (r_state == ISSUE) |=> (r_state != ISSUE));

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed bench for reg_file_arbiter with a transaction-level reference model.
module tb_reg_file_arbiter;

    logic            CLK;
    logic            RST;
    logic [1:0]      REQ;
    logic [1:0]      WR;
    logic [1:0][2:0] ADDR;
    logic [1:0][8:0] WDATA;
    logic [1:0]      GNT;
    logic [1:0]      RVALID;
    logic [8:0]      RDATA;
    logic            RF_WEN;
    logic            RF_OEN;
    logic [2:0]      RF_ADDR;
    logic [8:0]      RF_DIN;
    logic [8:0]      RF_DOUT;

    reg_file_arbiter dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .WR      (WR),
        .ADDR    (ADDR),
        .WDATA   (WDATA),
        .GNT     (GNT),
        .RVALID  (RVALID),
        .RDATA   (RDATA),
        .RF_WEN  (RF_WEN),
        .RF_OEN  (RF_OEN),
        .RF_ADDR (RF_ADDR),
        .RF_DIN  (RF_DIN),
        .RF_DOUT (RF_DOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file attached to the bus: write on WEN, registered read on OEN.
    logic [8:0] rf_mem [0:7];
    always @(posedge CLK) begin
        if (RF_WEN) rf_mem[RF_ADDR] <= RF_DIN;
        if (RF_OEN) RF_DOUT <= rf_mem[RF_ADDR];
    end

    // Reference model: each granted access becomes a list of per-cycle expected outputs.
    typedef struct packed {
        logic [1:0] gnt;
        logic [1:0] rvalid;
        logic       wen;
        logic       oen;
        logic [2:0] addr;
        logic [8:0] din;
        logic [8:0] rdata;
    } exp_t;

    exp_t       plan[$];
    exp_t       m_cur;
    exp_t       m_e;
    int         m_last;
    int         m_w;
    logic [8:0] m_mem [0:7];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            plan.delete();
            m_cur  = '0;
            m_last = 1;
        end else begin
            if (m_cur.wen) m_mem[m_cur.addr] = m_cur.din;
            if (plan.size() == 0 && m_cur.gnt == 2'b00 && m_cur.rvalid == 2'b00
                && REQ != 2'b00) begin
                if (REQ == 2'b11) m_w = (m_last == 0) ? 1 : 0;
                else              m_w = REQ[1] ? 1 : 0;
                m_last     = m_w;
                m_e        = '0;
                m_e.gnt    = (m_w == 1) ? 2'b10 : 2'b01;
                m_e.wen    = WR[m_w];
                m_e.oen    = !WR[m_w];
                m_e.addr   = ADDR[m_w];
                m_e.din    = WDATA[m_w];
                plan.push_back(m_e);
                if (!WR[m_w]) begin
                    m_e        = '0;
                    m_e.rvalid = (m_w == 1) ? 2'b10 : 2'b01;
                    m_e.rdata  = m_mem[ADDR[m_w]];
                    plan.push_back(m_e);
                end
            end
            m_cur = (plan.size() != 0) ? plan.pop_front() : '0;
        end
    end

    int         vectors;
    int         fails;
    bit         chk_en;
    logic [1:0] obs[$];
    int         gnt_cnt;
    int         wen_cnt;
    int         oen_cnt;
    logic [8:0] rd;

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_cycle();
        bit bad;
        vectors++;
        bad = (GNT !== m_cur.gnt) || (RVALID !== m_cur.rvalid) || (RF_WEN !== m_cur.wen)
              || (RF_OEN !== m_cur.oen) || (RDATA !== m_cur.rdata);
        if (m_cur.wen || m_cur.oen)
            bad = bad || (RF_ADDR !== m_cur.addr) || (RF_DIN !== m_cur.din);
        if (bad) begin
            fails++;
            $display("FAIL cycle_model t=%0t got gnt=%b rv=%b wen=%b oen=%b a=%h din=%h rd=%h want gnt=%b rv=%b wen=%b oen=%b a=%h din=%h rd=%h",
                     $time, GNT, RVALID, RF_WEN, RF_OEN, RF_ADDR, RF_DIN, RDATA,
                     m_cur.gnt, m_cur.rvalid, m_cur.wen, m_cur.oen, m_cur.addr, m_cur.din,
                     m_cur.rdata);
        end
        if (GNT != 2'b00) begin
            obs.push_back(GNT);
            gnt_cnt++;
        end
        if (RF_WEN) wen_cnt++;
        if (RF_OEN) oen_cnt++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_gnt(input int s);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (GNT[s] !== 1'b1 && n < 10);
        if (GNT[s] !== 1'b1) begin
            vectors++;
            fails++;
            $display("FAIL gnt_timeout: requester %0d got no grant in %0d cycles", s, n);
        end
    endtask

    task automatic access(input int s, input logic wr, input logic [2:0] a,
                          input logic [8:0] d, output logic [8:0] r);
        tick();
        REQ[s]   = 1'b1;
        WR[s]    = wr;
        ADDR[s]  = a;
        WDATA[s] = d;
        wait_gnt(s);
        tick();
        REQ[s] = 1'b0;
        r = '0;
        if (!wr) begin
            @(negedge CLK);
            lit("rd_rvalid", {30'd0, RVALID}, (s == 1) ? 32'd2 : 32'd1);
            r = RDATA;
        end
    endtask

    initial begin
        logic [1:0] exp_seq [0:5];
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        REQ = '0; WR = '0; ADDR = '0; WDATA = '0; RST = 1'b0;
        vectors = 0; fails = 0; chk_en = 0; gnt_cnt = 0; wen_cnt = 0; oen_cnt = 0;
        fork
            forever begin
                @(negedge CLK);
                if (chk_en) check_cycle();
            end
        join_none
        #1 RST = 1'b1;
        chk_en = 1;
        repeat (2) @(negedge CLK);
        lit("rst_gnt", {30'd0, GNT}, 32'd0);
        lit("rst_rvalid", {30'd0, RVALID}, 32'd0);
        lit("rst_rdata", {23'd0, RDATA}, 32'd0);
        lit("rst_strobes", {30'd0, RF_WEN, RF_OEN}, 32'd0);
        lit("rst_rf_addr", {29'd0, RF_ADDR}, 32'd0);
        lit("rst_rf_din", {23'd0, RF_DIN}, 32'd0);
        tick();
        RST = 1'b0;

        // Scenario 1: A writes then reads back address 3.
        access(0, 1'b1, 3'd3, 9'h055, rd);
        access(0, 1'b0, 3'd3, 9'h000, rd);
        lit("s1_rdata", {23'd0, rd}, 32'h055);

        // Scenario 2: reset, then a tie; A (write) must precede B (read).
        tick(); RST = 1'b1;
        tick(); RST = 1'b0;
        tick();
        REQ = 2'b11; WR = 2'b01;
        ADDR[0] = 3'd1; ADDR[1] = 3'd1; WDATA[0] = 9'h0AA; WDATA[1] = 9'h000;
        @(negedge CLK); @(negedge CLK);
        lit("s2_first_gnt", {30'd0, GNT}, 32'd1);
        tick(); REQ[0] = 1'b0;
        @(negedge CLK); @(negedge CLK);
        lit("s2_second_gnt", {30'd0, GNT}, 32'd2);
        tick(); REQ[1] = 1'b0;
        @(negedge CLK);
        lit("s2_rvalid", {30'd0, RVALID}, 32'd2);
        lit("s2_rdata", {23'd0, RDATA}, 32'h0AA);

        // Scenario 3: both hold write requests for six accesses.
        tick();
        obs.delete();
        REQ = 2'b11; WR = 2'b11;
        ADDR[0] = 3'd4; ADDR[1] = 3'd5; WDATA[0] = 9'h1C3; WDATA[1] = 9'h03C;
        repeat (12) tick();
        REQ = 2'b00;
        repeat (3) tick();
        lit("s3_grant_count", obs.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < obs.size()) lit("s3_grant_order", {30'd0, obs[i]}, {30'd0, exp_seq[i]});
        end

        // Scenario 4: fill all eight entries, then read them back.
        wen_cnt = 0; oen_cnt = 0;
        for (int a = 0; a < 8; a++) access(0, 1'b1, 3'(a), 9'(a * 33), rd);
        for (int a = 0; a < 8; a++) begin
            access(0, 1'b0, 3'(a), 9'h000, rd);
            lit("s4_rdata", {23'd0, rd}, 32'(a * 33));
        end
        tick();
        lit("s4_wen_cycles", wen_cnt, 32'd8);
        lit("s4_oen_cycles", oen_cnt, 32'd8);

        // Scenario 5: reset lands in CAPTURE of a B read.
        tick();
        REQ[1] = 1'b1; WR[1] = 1'b0; ADDR[1] = 3'd5;
        wait_gnt(1);
        tick();
        REQ[1] = 1'b0;
        #1 RST = 1'b1;
        #1;
        lit("s5_rvalid", {30'd0, RVALID}, 32'd0);
        lit("s5_rdata", {23'd0, RDATA}, 32'd0);
        lit("s5_strobes", {30'd0, RF_WEN, RF_OEN}, 32'd0);
        tick(); RST = 1'b0;
        tick();
        REQ = 2'b11; WR = 2'b11;
        ADDR[0] = 3'd2; ADDR[1] = 3'd7; WDATA[0] = 9'h111; WDATA[1] = 9'h0F0;
        @(negedge CLK); @(negedge CLK);
        lit("s5_tie_gnt", {30'd0, GNT}, 32'd1);
        tick(); REQ[0] = 1'b0;
        wait_gnt(1);
        tick(); REQ = 2'b00;
        repeat (2) tick();

        // Scenario 6: A pulses REQ inside one idle cycle, never seen at an edge.
        gnt_cnt = 0; wen_cnt = 0; oen_cnt = 0;
        tick();
        REQ[0] = 1'b1; WR[0] = 1'b1; ADDR[0] = 3'd0; WDATA[0] = 9'h1AB;
        #2 REQ[0] = 1'b0;
        repeat (4) @(negedge CLK);
        lit("s6_no_gnt", gnt_cnt, 32'd0);
        lit("s6_no_strobes", wen_cnt + oen_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
